// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier controller: FSM states,
// Booth digit operations and the multiplier-triple recoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_op_e;

    // Radix-4 recoding of {Q[1], Q[0], q_m1}
    function automatic booth_op_e recode(input logic [2:0] triple);
        booth_op_e op;
        case (triple)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = N2M;
            3'b101, 3'b110: op = NM;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Booth digit encoder: selects the magnitude 0/M/2M and flags negation.
module booth_r4_enc
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2:0]       triple_i,
    input  logic [WIDTH+1:0] m_i,
    output logic [WIDTH+1:0] mult_o,
    output logic             neg_o
);

    always_comb begin
        mult_o = '0;
        neg_o  = 1'b0;
        case (recode(triple_i))
            PM:  mult_o = m_i;
            P2M: mult_o = {m_i[WIDTH:0], 1'b0};
            NM: begin
                mult_o = m_i;
                neg_o  = 1'b1;
            end
            N2M: begin
                mult_o = {m_i[WIDTH:0], 1'b0};
                neg_o  = 1'b1;
            end
            default: mult_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: drives a shared external
// (WIDTH+2)-bit adder for WIDTH/2 steps per operand pair, valid/ready on both sides.
module booth_r4_seq_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [WIDTH+1:0]     add_op_a,
    output logic [WIDTH+1:0]     add_op_b,
    output logic                 add_cin,
    input  logic [WIDTH+1:0]     add_sum
);

    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(HALF) + 1;
    localparam int unsigned SH_W  = AW + WIDTH + 1;

    state_e               state_q, state_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        p_q, p_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [AW-1:0]        add_a_q, add_a_d;
    logic [AW-1:0]        add_b_q, add_b_d;
    logic                 add_cin_q, add_cin_d;
    logic [AW-1:0]        mult_nx;
    logic                 neg_nx;
    logic signed [SH_W-1:0] shifted;

    // Accumulate-and-shift of {P, Q, q_m1} using the adder result
    assign shifted = $signed({add_sum, q_q, qm1_q}) >>> 2;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                p_d   = shifted[SH_W-1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    state_d   = DONE;
                    product_d = shifted[2*WIDTH:1];
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new pair may be taken from IDLE or in the same cycle as a pay-out
        if (in_valid && in_ready) begin
            state_d = RUN;
            m_d     = {{2{a[WIDTH-1]}}, a};
            p_d     = '0;
            q_d     = b;
            qm1_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .triple_i ({q_d[1:0], qm1_d}),
        .m_i      (m_d),
        .mult_o   (mult_nx),
        .neg_o    (neg_nx)
    );

    // Adder operands are prepared one cycle ahead so they leave from flops
    always_comb begin
        add_a_d   = '0;
        add_b_d   = '0;
        add_cin_d = 1'b0;
        if (state_d == RUN) begin
            add_a_d   = p_d;
            add_b_d   = neg_nx ? ~mult_nx : mult_nx;
            add_cin_d = neg_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            p_q         <= p_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN);
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;
    assign add_op_a  = add_a_q;
    assign add_op_b  = add_b_q;
    assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed and randomized bench for booth_r4_seq_ctrl at WIDTH=8 with a behavioural adder.
module tb_booth_r4_seq_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = W + 2;
    localparam int          N_RAND = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  a;
    logic signed [W-1:0]  b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*W-1:0]       product;
    logic                 busy;
    logic [AW-1:0]        add_op_a;
    logic [AW-1:0]        add_op_b;
    logic                 add_cin;
    logic [AW-1:0]        add_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign add_sum = add_op_a + add_op_b + AW'(add_cin);

    booth_r4_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .add_op_a  (add_op_a),
        .add_op_b  (add_op_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issue one pair from IDLE and wait (bounded) for out_valid; returns at the negedge it is seen
    task automatic run_op(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                          output int prod, output int lat, output int bcnt);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        prod = $signed(product);
    endtask

    task automatic wait_valid(output int prod);
        prod = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("wait_valid", int'(out_valid), 1);
        prod = $signed(product);
    endtask

    initial begin
        int p, lat, bc, seen, sent, rcvd, e;
        int exp_q[$];

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_product", int'(product), 0);
        check("rst_add_a", int'(add_op_a), 0);
        check("rst_add_b", int'(add_op_b), 0);
        check("rst_add_cin", int'(add_cin), 0);

        // 1: basic op, latency and busy duration
        run_op(8'sd3, 8'sd5, p, lat, bc);
        check("t1_prod", p, 15);
        check("t1_latency", lat, 5);
        check("t1_busy_cycles", bc, 4);

        // 2: corner operands
        run_op(-8'sd128, -8'sd128, p, lat, bc);
        check("t2_minmin", p, 16384);
        run_op(-8'sd128, 8'sd127, p, lat, bc);
        check("t2_minmax", p, -16256);
        run_op(-8'sd7, 8'sd9, p, lat, bc);
        check("t2_m7x9", p, -63);

        // 3: zero/one results and idle adder operands
        run_op(8'sd0, -8'sd1, p, lat, bc);
        check("t3_0xm1", p, 0);
        run_op(-8'sd1, -8'sd1, p, lat, bc);
        check("t3_m1xm1", p, 1);
        check("t3_done_add_a", int'(add_op_a), 0);
        check("t3_done_add_b", int'(add_op_b), 0);
        check("t3_done_add_cin", int'(add_cin), 0);
        @(negedge clk);
        check("t3_idle_state", int'(in_ready), 1);
        check("t3_idle_add_a", int'(add_op_a), 0);
        check("t3_idle_add_b", int'(add_op_b), 0);
        check("t3_idle_add_cin", int'(add_cin), 0);

        // 4: backpressure with ignored in_valid, then same-cycle pay-out and accept
        out_ready = 1'b0;
        run_op(8'sd5, 8'sd6, p, lat, bc);
        check("t4_first", p, 30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 8'sd9;
            b = 8'sd9;
            in_valid = 1'b1;
            #1;
            check("t4_hold_prod", $signed(product), 30);
            check("t4_hold_valid", int'(out_valid), 1);
            check("t4_hold_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        a = 8'sd2;
        b = -8'sd3;
        out_ready = 1'b1;
        #1;
        check("t4_b2b_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t4_b2b_busy", int'(busy), 1);
        check("t4_b2b_valid", int'(out_valid), 0);
        wait_valid(p);
        check("t4_b2b_prod", p, -6);

        // 5: async reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a = 8'sd5;
        b = 8'sd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("t5_no_valid", seen, 0);
        run_op(8'sd4, 8'sd4, p, lat, bc);
        check("t5_after", p, 16);

        // 6: random pairs with random handshakes, in-order scoreboard
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 60000 && rcvd < N_RAND; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            a = W'($urandom);
            b = W'($urandom);
            in_valid = (sent < N_RAND) && ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_prod", $signed(product), e);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(int'(a) * int'(b));
                sent++;
            end
        end
        in_valid = 1'b0;
        check("rand_count", rcvd, N_RAND);
        check("rand_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
